// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - op codes, FSM states and op-class helpers for the iterative mul/div unit
package mdu_iter_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'd0,
        MDU_S_RUN  = 2'd1,
        MDU_S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_iter(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// rtl/mdu_shift_core.sv - shared 2*WIDTH shift register doing one shift-add (mul) or
// restoring trial-subtract (div) step per cycle
module mdu_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_load,
    input  logic [2*WIDTH-1:0]   i_load_val,
    input  logic                 i_step,
    input  logic                 i_div,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_sr
);

    logic [2*WIDTH-1:0] r_sr;
    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;

    // mul: {hi,lo} = {partial, multiplier}; div: {hi,lo} = {remainder, dividend/quotient}
    always_comb begin
        w_sum   = {1'b0, r_sr[2*WIDTH-1:WIDTH]} + (r_sr[0] ? {1'b0, i_operand} : '0);
        w_trial = r_sr[2*WIDTH-1:WIDTH-1] - {1'b0, i_operand};
        w_next  = {w_sum, r_sr[WIDTH-1:1]};
        if (i_div) begin
            if (!w_trial[WIDTH]) begin
                w_next = {w_trial[WIDTH-1:0], r_sr[WIDTH-2:0], 1'b1};
            end else begin
                w_next = {r_sr[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_load_val;
        end else if (i_step) begin
            r_sr <= w_next;
        end
    end

    assign o_sr = r_sr;

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO
// Optional MDU_DIVZERO_FLAG_EN adds a div0 output flagging divide-by-zero completions.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef MDU_DIVZERO_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         r_state, w_next_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_neg_main, r_neg_rem, r_b_zero, r_done;
    logic [WIDTH-1:0]   r_a_raw, r_operand, r_hi, r_lo;

    logic               w_accept, w_go, w_is_div, w_signed, w_sa, w_sb, w_step;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [2*WIDTH-1:0] w_sr, w_load_val, w_prod;

    assign w_accept = start && (r_state == MDU_S_IDLE);
    assign w_go     = w_accept && op_is_iter(op);
    assign w_is_div = op_is_div(op);
    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_sa     = w_signed && a[WIDTH-1];
    assign w_sb     = w_signed && b[WIDTH-1];
    // -0x80..0 wraps to itself, which read unsigned is the correct magnitude
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;
    assign w_load_val = {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
    assign w_step   = (r_state == MDU_S_RUN);

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_go),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_div      (r_div),
        .i_operand  (r_operand),
        .o_sr       (w_sr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= MDU_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MDU_S_IDLE: if (w_go) w_next_state = MDU_S_RUN;
            MDU_S_RUN:  if (r_cnt == LAST) w_next_state = MDU_S_FIX;
            MDU_S_FIX:  w_next_state = MDU_S_IDLE;
            default:    w_next_state = MDU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_div      <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a_raw    <= '0;
            r_operand  <= '0;
        end else if (w_go) begin
            r_cnt      <= '0;
            r_div      <= w_is_div;
            r_neg_main <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_b_zero   <= (b == '0);
            r_a_raw    <= a;
            r_operand  <= w_is_div ? w_abs_b : w_abs_a;
        end else if (w_step) begin
            r_cnt      <= r_cnt + CW'(1);
        end
    end

    assign w_prod = r_neg_main ? -w_sr : w_sr;
    assign w_quo  = w_sr[WIDTH-1:0];
    assign w_rem  = w_sr[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_rem  ? -w_rem : w_rem;
                w_res_lo = r_neg_main ? -w_quo : w_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == MDU_S_FIX);
            if (r_state == MDU_S_FIX) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_accept && (op == MDU_MTHI)) begin
                r_hi <= a;
            end else if (w_accept && (op == MDU_MTLO)) begin
                r_lo <= a;
            end
        end
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_div0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div0 <= 1'b0;
        end else if (r_state == MDU_S_FIX) begin
            r_div0 <= r_div && r_b_zero;
        end else if (w_accept) begin
            r_div0 <= 1'b0;
        end
    end

    assign div0 = r_div0;
`endif

    assign busy = (r_state != MDU_S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter against a plain-arithmetic reference model
module tb_mdu_iter;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                           OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic         div0;
`endif

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
`ifdef MDU_DIVZERO_FLAG_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed/unsigned arithmetic; SV division truncates toward zero
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    exp_hi = a;
                    exp_lo = '1;
                end else if (op == OP_DIVU) begin
                    exp_hi = a % b;
                    exp_lo = a / b;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_hi = W'(r);
                    exp_lo = W'(q);
                end
            end
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the edge on which done rose
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_k, input string tag);
        int k;
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, ":busy_after_start"}, busy, 1);
`ifdef MDU_DIVZERO_FLAG_EN
        check_eq({tag, ":div0_cleared"}, div0, 0);
`endif
        k = 0;
        while (k < 3 * W) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (k == inj_k) begin
                start = 1'b1; op_i = OP_MTHI; a_i = 32'h1234;
            end else if (k == inj_k + 1) begin
                start = 1'b0;
            end
            if (k == W / 2) begin
                check_eq({tag, ":hi_stable"}, hi, exp_hi);
                check_eq({tag, ":lo_stable"}, lo, exp_lo);
            end
        end
        start = 1'b0;
        model(op, a, b);
        check_eq({tag, ":latency"}, k, W + 1);
        check_eq({tag, ":hi"}, hi, exp_hi);
        check_eq({tag, ":lo"}, lo, exp_lo);
        check_eq({tag, ":busy_at_done"}, busy, 0);
`ifdef MDU_DIVZERO_FLAG_EN
        check_eq({tag, ":div0"}, div0, ((op == OP_DIV || op == OP_DIVU) && b == 0));
`endif
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [W-1:0] a, input string tag);
        start = 1'b1; op_i = op; a_i = a;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == OP_MTHI) exp_hi = a;
        else if (op == OP_MTLO) exp_lo = a;
        check_eq({tag, ":hi"}, hi, exp_hi);
        check_eq({tag, ":lo"}, lo, exp_lo);
        check_eq({tag, ":busy"}, busy, 0);
        check_eq({tag, ":done"}, done, 0);
    endtask

    initial begin
        logic [2:0]   r_op;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst:busy", busy, 0);
        check_eq("rst:done", done, 0);
        check_eq("rst:hi", hi, 0);
        check_eq("rst:lo", lo, 0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, -1, "mult_neg");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, -1, "mult_minmin");
        run_op(OP_DIV,   -32'sd7, 32'd2, -1, "div_neg7");
        run_op(OP_DIVU,  32'd7, 32'd2, -1, "divu_7_2");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        run_op(OP_DIVU,  32'd5, 32'd0, -1, "divu_by0");
        run_op(OP_DIV,   -32'sd5, 32'd0, -1, "div_by0_neg");
        run_op(OP_DIV,   -32'sd9, -32'sd4, -1, "div_negneg");

        run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_FF00, 5, "mult_mthi_ignored");
        mt_op(OP_MTLO, 32'h0000_ABCD, "mtlo_idle");
        mt_op(OP_MTHI, 32'h5555_0001, "mthi_idle");

        start = 1'b1; op_i = 3'd6; a_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("bad_op:busy", busy, 0);
        check_eq("bad_op:hi", hi, exp_hi);
        check_eq("bad_op:lo", lo, exp_lo);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'd1;
                4: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            run_op(r_op, ra, rb, -1, "rnd");
        end

        start = 1'b1; op_i = OP_DIV; a_i = 32'd1000; b_i = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check_eq("abort:busy", busy, 0);
        check_eq("abort:done", done, 0);
        check_eq("abort:hi", hi, exp_hi);
        check_eq("abort:lo", lo, exp_lo);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd9, 32'd3, -1, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
